mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Control-unit side bundle for mult_div_unit: launch/operands, MTHI/MTLO writes, status and HI/LO.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_write, lo_write, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_write, lo_write, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with HI/LO registers (radix-2, one step per cycle).
// Signed MULT/DIV support is built only when MDU_SIGNED_EN is defined; otherwise op[0] is ignored.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p_hi, p_lo, d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div, dz;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH-1:0] op_a, op_b;
  logic             div_by_zero;

  assign div_by_zero = bus.op[1] && (bus.b == '0);

`ifdef MDU_SIGNED_EN
  logic sgn, neg_q, neg_r, neg_q_in, neg_r_in;

  assign sgn      = ~bus.op[0];
  assign op_a     = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign op_b     = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign neg_q_in = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && !div_by_zero;
  assign neg_r_in = sgn && bus.op[1] && bus.a[WIDTH-1] && !div_by_zero;
`else
  logic unused_op0;

  assign unused_op0 = bus.op[0];
  assign op_a       = bus.a;
  assign op_b       = bus.b;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = div_by_zero ? FIX : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared {p_hi,p_lo} pair: multiply shifts right (product ends up in place),
  // divide shifts left with quotient bits entering p_lo and remainder in p_hi.
  always_comb begin
    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, d} : '0);
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], p_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {p_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    fix_hi = p_hi;
    fix_lo = p_lo;
`ifdef MDU_SIGNED_EN
    if (is_div) begin
      if (neg_q) fix_lo = -p_lo;
      if (neg_r) fix_hi = -p_hi;
    end else if (neg_q) begin
      {fix_hi, fix_lo} = -{p_hi, p_lo};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      d      <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MDU_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= CNT_W'(WIDTH);
            is_div <= bus.op[1];
            dz     <= div_by_zero;
`ifdef MDU_SIGNED_EN
            neg_q  <= neg_q_in;
            neg_r  <= neg_r_in;
`endif
            // Divide by zero skips CALC: the final HI/LO are staged here directly.
            if (div_by_zero) begin
              p_hi <= bus.a;
              p_lo <= '1;
              d    <= '0;
            end else if (bus.op[1]) begin
              p_hi <= '0;
              p_lo <= op_a;
              d    <= op_b;
            end else begin
              p_hi <= '0;
              p_lo <= op_b;
              d    <= op_a;
            end
          end else begin
            if (bus.hi_write) hi_q <= bus.wdata;
            if (bus.lo_write) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          cnt  <= cnt - CNT_W'(1);
          p_hi <= step_hi;
          p_lo <= step_lo;
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.div_zero = dz;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): vector table, hand sequences, random ops vs arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;
`ifdef MDU_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] sel(input logic [W-1:0] s, input logic [W-1:0] u);
    return SIGNED_EN ? s : u;
  endfunction

  // Reference: plain 64-bit / int arithmetic on the architectural semantics.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic edz);
    bit          sgn;
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sgn = SIGNED_EN && !op[0];
    edz = 1'b0;
    if (!op[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      ehi = p[63:32];
      elo = p[31:0];
    end else if (b == '0) begin
      elo = '1;
      ehi = a;
      edz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        elo = a;
        ehi = '0;
      end else begin
        ia  = $signed(a);
        ib  = $signed(b);
        elo = ia / ib;
        ehi = ia % ib;
      end
    end else begin
      elo = a / b;
      ehi = a % b;
    end
  endfunction

  // Called #1 after a rising edge; that next edge is edge 0. Cycle n is the interval after edge n-1.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                        output logic [W-1:0] ohi, output logic [W-1:0] olo, output logic odz,
                        output int lat, output bit busy_ok, output bit hold_ok);
    int n;
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    n = 1; lat = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (n <= 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.hi !== cur_hi || bus.lo !== cur_lo) hold_ok = 1'b0;
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = '0;
        bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdata = 32'h0000_FFFF;
      end else if (inject && n == 6) begin
        bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    ohi = bus.hi; olo = bus.lo; odz = bus.div_zero;
  endtask

  task automatic check_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input int elat, input bit inject);
    logic [W-1:0] ohi, olo;
    logic         odz;
    int           lat;
    bit           busy_ok, hold_ok;
    run_op(op, a, b, inject, ohi, olo, odz, lat, busy_ok, hold_ok);
    check($sformatf("%s.latency", tag), 64'(lat), 64'(elat));
    check($sformatf("%s.hi", tag), 64'(ohi), 64'(ehi));
    check($sformatf("%s.lo", tag), 64'(olo), 64'(elo));
    check($sformatf("%s.div_zero", tag), 64'(odz), 64'(edz));
    check($sformatf("%s.busy_during", tag), 64'(busy_ok), 64'(1));
    check($sformatf("%s.hold_until_done", tag), 64'(hold_ok), 64'(1));
    cur_hi = ehi;
    cur_lo = elo;
    @(posedge clock); #1;
    check($sformatf("%s.idle_after", tag), {62'b0, bus.busy, bus.done}, 64'(0));
  endtask

  vec_t vecs[10];

  initial begin
    logic [W-1:0] ehi, elo, ra, rb;
    logic         edz;
    logic [1:0]   rop;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.wdata = '0;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5, sel(32'hFFFF_FFFF, 32'h0000_0004), 32'hFFFF_FFF1, 1'b0, 34};
    vecs[1] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2, sel(32'hFFFF_FFFF, 32'd1), sel(32'hFFFF_FFFD, 32'h7FFF_FFFC), 1'b0, 34};
    vecs[3] = '{2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[4] = '{2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, sel(32'd0, 32'h8000_0000), sel(32'h8000_0000, 32'd0), 1'b0, 34};
    vecs[6] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[7] = '{2'b11, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 34};
    vecs[9] = '{2'b10, 32'd7, 32'hFFFF_FFFE, sel(32'd1, 32'd7), sel(32'hFFFF_FFFD, 32'd0), 1'b0, 34};

    repeat (3) @(posedge clock);
    #1;
    check("reset.busy", 64'(bus.busy), 64'(0));
    check("reset.done", 64'(bus.done), 64'(0));
    check("reset.div_zero", 64'(bus.div_zero), 64'(0));
    check("reset.hi", 64'(bus.hi), 64'(0));
    check("reset.lo", 64'(bus.lo), 64'(0));
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat, 1'b0);

    // Start and MTHI/MTLO while busy must be ignored.
    check_op("busy_ignore", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 1'b1);

    bus.hi_write = 1'b1; bus.wdata = 32'h0000_ABCD;
    @(posedge clock); #1;
    bus.hi_write = 1'b0;
    check("mthi.hi", 64'(bus.hi), 64'h0000_ABCD);
    check("mthi.lo", 64'(bus.lo), 64'd12);
    cur_hi = 32'h0000_ABCD;

    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdata = 32'h5555_AAAA;
    @(posedge clock); #1;
    bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    check("mthi_mtlo.hi", 64'(bus.hi), 64'h5555_AAAA);
    check("mthi_mtlo.lo", 64'(bus.lo), 64'h5555_AAAA);
    cur_hi = 32'h5555_AAAA;
    cur_lo = 32'h5555_AAAA;

    // Start and writes in the same IDLE cycle: writes dropped (hold check covers it).
    bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdata = 32'h0BAD_0BAD;
    check_op("start_wins", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34, 1'b0);

    // Asynchronous reset in cycle 10 of a DIVU.
    bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort.busy", 64'(bus.busy), 64'(0));
    check("abort.done", 64'(bus.done), 64'(0));
    check("abort.hi", 64'(bus.hi), 64'(0));
    check("abort.lo", 64'(bus.lo), 64'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    @(posedge clock); #1;
    check_op("after_reset", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = 32'($urandom_range(1, 20));
        3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, ehi, elo, edz);
      check_op($sformatf("rand%0d", i), rop, ra, rb, ehi, elo, edz,
               (rop[1] && rb == '0) ? 2 : 34, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
